// File: rtl/bcd_countdown_timer_pkg.sv
// ==========================================================================
// timer_pkg : shared constants and digit-limit helper for the BCD timer
// Rev 1.0
// ==========================================================================
`default_nettype none

package timer_pkg;

  localparam int              BCD_W              = 4;
  localparam logic [BCD_W-1:0] DIGIT_MAX_DEC      = 4'd9;
  localparam logic [BCD_W-1:0] DIGIT_MAX_SEC_TENS = 4'd5;

  // Digit 1 is seconds-tens (mod 6); every other digit is mod 10.
  function automatic logic [BCD_W-1:0] digit_max(input int idx);
    return (idx == 1) ? DIGIT_MAX_SEC_TENS : DIGIT_MAX_DEC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_countdown_timer_if.sv
// ==========================================================================
// bcd_countdown_timer_if : load/enable/time bus between controller and timer
// Rev 1.0
// ==========================================================================
`default_nettype none

interface bcd_countdown_timer_if
  import timer_pkg::*;
#(
  parameter int MIN_DIGITS = 2
) ();

  localparam int W = BCD_W * (MIN_DIGITS + 2);

  logic         loadn;
  logic         en;
  logic [W-1:0] data;
  logic [W-1:0] out;
  logic         zero;
  logic         done;

  modport master (output loadn, en, data, input  out, zero, done);
  modport slave  (input  loadn, en, data, output out, zero, done);

endinterface

`default_nettype wire

// File: rtl/bcd_countdown_timer_digit.sv
// ==========================================================================
// bcd_digit_down : one BCD down-counting digit with clamp-on-load and wrap
// Rev 1.0
// ==========================================================================
`default_nettype none

module bcd_digit_down
  import timer_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = DIGIT_MAX_DEC
) (
  input  wire logic             clk,
  input  wire logic             clrn,
  input  wire logic             loadn,
  input  wire logic             bin,
  input  wire logic [BCD_W-1:0] data,
  output logic      [BCD_W-1:0] out,
  output logic                  bout,
  output logic                  zero
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (!loadn) begin
      digit_d = (data > MAX) ? MAX : data;
    end else if (bin) begin
      digit_d = (digit_q == '0) ? MAX : digit_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign out  = digit_q;
  assign zero = (digit_q == '0);
  assign bout = bin & zero;

endmodule

`default_nettype wire

// File: rtl/bcd_countdown_timer.sv
// ==========================================================================
// bcd_countdown_timer : MM..M:SS BCD countdown with clamp, saturation, done
// Rev 1.0
// ==========================================================================
`default_nettype none

module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int MIN_DIGITS = 2
) (
  input  wire logic             clk,
  input  wire logic             clrn,
  bcd_countdown_timer_if.slave  bus
);

  localparam int D = MIN_DIGITS + 2;
  localparam int W = BCD_W * D;

  logic [W-1:0] w_out;
  logic [D-1:0] w_bin;
  logic [D-1:0] w_bout;
  logic [D-1:0] w_dzero;
  logic         w_zero;
  logic         w_one;
  logic         done_q;
  logic         done_d;

  assign w_zero = &w_dzero;
  assign w_one  = (w_out == W'(1));

  // Gating the first borrow with ~zero gives saturation at 00:00.
  assign w_bin[0] = bus.en & ~w_zero;

  generate
    for (genvar i = 0; i < D; i++) begin : g_digit
      localparam logic [BCD_W-1:0] C_MAX = digit_max(i);

      if (i > 0) begin : g_chain
        assign w_bin[i] = w_bout[i-1];
      end

      bcd_digit_down #(
        .MAX (C_MAX)
      ) u_digit (
        .clk   (clk),
        .clrn  (clrn),
        .loadn (bus.loadn),
        .bin   (w_bin[i]),
        .data  (bus.data[i*BCD_W +: BCD_W]),
        .out   (w_out[i*BCD_W +: BCD_W]),
        .bout  (w_bout[i]),
        .zero  (w_dzero[i])
      );
    end
  endgenerate

  // 00:01 decremented is the only step that lands on zero; a top-digit borrow
  // would mean underflow, which saturation already prevents.
  assign done_d = bus.loadn & w_bin[0] & w_one & ~w_bout[D-1];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign bus.out  = w_out;
  assign bus.zero = w_zero;
  assign bus.done = done_q;

endmodule

`default_nettype wire
